// File: rtl/fetch_pkg.sv
// Shared types and sizes for the instruction fetch sequencer.
package fetch_pkg;

  localparam int unsigned BYTES_PER_INSTR = 4;
  localparam int unsigned INSTR_W         = 32;
  localparam int unsigned BYTE_W          = 8;
  localparam int unsigned CNT_W           = 2;

  // Controller states: byte reads, final byte capture, word held for decode.
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    LAST  = 2'd1,
    VALID = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_sequencer_if.sv
// ROM, decode and redirect signals of the fetch sequencer, grouped as one bus.
interface fetch_sequencer_if #(
  parameter int unsigned ADDR_W = 8
);
  import fetch_pkg::*;

  logic [ADDR_W-1:0]  rom_addr;
  logic [BYTE_W-1:0]  rom_q;
  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  instr_pc;
  logic               instr_valid;
  logic               instr_ready;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               busy;
  logic               misalign_err;

  // Sequencer side.
  modport master (
    output rom_addr, instr, instr_pc, instr_valid, busy, misalign_err,
    input  rom_q, instr_ready, redirect_valid, redirect_pc
  );

  // ROM / decode / execute side.
  modport slave (
    input  rom_addr, instr, instr_pc, instr_valid, busy, misalign_err,
    output rom_q, instr_ready, redirect_valid, redirect_pc
  );

endinterface

// File: rtl/fetch_byte_assembler.sv
// Four byte slots written one at a time, presented as a big-endian word.
module fetch_byte_assembler
  import fetch_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [CNT_W-1:0]   wr_idx,
  input  logic [BYTE_W-1:0]  wr_data,
  output logic [INSTR_W-1:0] word
);

  logic [BYTES_PER_INSTR-1:0][BYTE_W-1:0] slot_q;

  // Slot storage; slot 0 holds the byte at the lowest address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q <= '0;
    end else if (wr_en) begin
      slot_q[wr_idx] <= wr_data;
    end
  end

  // Lowest-address byte lands in the most significant position.
  always_comb begin
    word = {slot_q[0], slot_q[1], slot_q[2], slot_q[3]};
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: PC, four byte reads per word, decode handshake,
// redirects. Optional FETCH_ALIGN_CHECK_EN rejects word-misaligned redirects.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned RESET_PC = 0
) (
  input logic             clk,
  input logic             rst,
  fetch_sequencer_if.master bus
);

  localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_PC);

  fetch_state_e      state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
  logic              valid_q, busy_q, misalign_q, misalign_d;
  logic              accept_c;
  logic              wr_en_c;
  logic [CNT_W-1:0]  wr_idx_c;

  // Redirect acceptance and misalignment flag.
  always_comb begin
`ifdef FETCH_ALIGN_CHECK_EN
    accept_c   = bus.redirect_valid && (bus.redirect_pc[1:0] == 2'b00);
    misalign_d = bus.redirect_valid && !accept_c;
`else
    accept_c   = bus.redirect_valid;
    misalign_d = 1'b0;
`endif
  end

  // Next state, PC, slot writes and next registered outputs.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pc_d       = pc_q;
    instr_pc_d = instr_pc_q;
    wr_en_c    = 1'b0;
    wr_idx_c   = CNT_W'(cnt_q - CNT_W'(1));
    case (state_q)
      FETCH: begin
        wr_en_c = (cnt_q != '0);
        cnt_d   = CNT_W'(cnt_q + CNT_W'(1));
        if (cnt_q == CNT_W'(BYTES_PER_INSTR - 1)) state_d = LAST;
      end
      LAST: begin
        wr_en_c    = 1'b1;
        wr_idx_c   = CNT_W'(BYTES_PER_INSTR - 1);
        instr_pc_d = pc_q;
        state_d    = VALID;
      end
      VALID: begin
        if (bus.instr_ready) begin
          pc_d    = pc_q + ADDR_W'(BYTES_PER_INSTR);
          cnt_d   = '0;
          state_d = FETCH;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = FETCH;
      end
    endcase
    if (accept_c) begin
      pc_d       = bus.redirect_pc;
      cnt_d      = '0;
      state_d    = FETCH;
      wr_en_c    = 1'b0;
      instr_pc_d = instr_pc_q;
    end
    if (state_d == FETCH) rom_addr_d = pc_d + ADDR_W'(cnt_d);
    else                  rom_addr_d = pc_d + ADDR_W'(BYTES_PER_INSTR - 1);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= FETCH;
      cnt_q      <= '0;
      pc_q       <= RST_PC;
      rom_addr_q <= RST_PC;
      instr_pc_q <= RST_PC;
      valid_q    <= 1'b0;
      busy_q     <= 1'b1;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pc_q       <= pc_d;
      rom_addr_q <= rom_addr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= (state_d == VALID);
      busy_q     <= (state_d != VALID);
      misalign_q <= misalign_d;
    end
  end

  fetch_byte_assembler u_asm (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en_c),
    .wr_idx  (wr_idx_c),
    .wr_data (bus.rom_q),
    .word    (bus.instr)
  );

  assign bus.rom_addr     = rom_addr_q;
  assign bus.instr_pc     = instr_pc_q;
  assign bus.instr_valid  = valid_q;
  assign bus.busy         = busy_q;
  assign bus.misalign_err = misalign_q;

endmodule
